// File: rtl/sar_ctrl_pkg.sv
// Shared types and defaults for the SAR ADC round-robin scan controller.
package sar_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CONVERT = 2'd2,
        OUTPUT  = 2'd3
    } scan_state_t;

    localparam int N_BITS_DEF = 10;
    localparam int N_CH_DEF   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first requesting channel after 'last', wrapping.
module rr_arbiter #(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]         req,
    input  logic [$clog2(N_CH)-1:0] last,
    output logic [$clog2(N_CH)-1:0] gnt_idx,
    output logic                    gnt_valid
);

    localparam int IDX_W = $clog2(N_CH);

    int idx_s;

    // Walk offsets from farthest to nearest so the nearest requester after 'last' wins
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx_s     = 0;
        for (int i = N_CH; i >= 1; i--) begin
            idx_s     = (int'(last) + i) % N_CH;
            gnt_idx   = req[idx_s] ? IDX_W'(idx_s) : gnt_idx;
            gnt_valid = gnt_valid | req[idx_s];
        end
    end

endmodule

// File: rtl/sar_adc_scan_ctrl.sv
// Round-robin multi-channel scan controller: channel select, settle, hold/convert
// under a timeout, and valid/ready delivery of the tagged result.
module sar_adc_scan_ctrl
    import sar_ctrl_pkg::*;
#(
    parameter int N_CH          = N_CH_DEF,
    parameter int N_BITS        = N_BITS_DEF,
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [N_CH-1:0]         ch_req,
    output logic [$clog2(N_CH)-1:0] mux_sel,
    output logic                    adc_hold,
    input  logic                    adc_eoc,
    input  logic [N_BITS-1:0]       adc_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [N_BITS-1:0]       res_data,
    output logic [$clog2(N_CH)-1:0] res_ch,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int CH_W    = $clog2(N_CH);
    localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT) ? SETTLE_CYCLES : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    scan_state_t       state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [CH_W-1:0]   last_ch_r;
    logic [CH_W-1:0]   gnt_idx_s;
    logic              gnt_valid_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (ch_req),
        .last      (last_ch_r),
        .gnt_idx   (gnt_idx_s),
        .gnt_valid (gnt_valid_s)
    );

    // Scan FSM; every output is a register updated alongside the state transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            last_ch_r   <= CH_W'(N_CH - 1);
            mux_sel     <= '0;
            adc_hold    <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_ch      <= '0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable && gnt_valid_s) begin
                        mux_sel <= gnt_idx_s;
                        busy    <= 1'b1;
                        cnt_r   <= '0;
                        state_r <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_r == SETTLE_LAST) begin
                        adc_hold <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= CONVERT;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                CONVERT: begin
                    // eoc takes priority over a coincident timeout terminal count
                    if (adc_eoc) begin
                        res_data  <= adc_result;
                        res_ch    <= mux_sel;
                        last_ch_r <= mux_sel;
                        adc_hold  <= 1'b0;
                        res_valid <= 1'b1;
                        cnt_r     <= '0;
                        state_r   <= OUTPUT;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        err_timeout <= 1'b1;
                        last_ch_r   <= mux_sel;
                        adc_hold    <= 1'b0;
                        busy        <= 1'b0;
                        cnt_r       <= '0;
                        state_r     <= IDLE;
                    end else begin
                        cnt_r <= sat_inc(cnt_r);
                    end
                end
                OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    adc_hold  <= 1'b0;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_adc_scan_ctrl.sv
// Directed self-checking bench for sar_adc_scan_ctrl with a behavioural ADC model.
module tb_sar_adc_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] ch_req;
    logic [1:0] mux_sel;
    logic       adc_hold;
    logic       adc_eoc;
    logic [9:0] adc_result;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_data;
    logic [1:0] res_ch;
    logic       busy;
    logic       err_timeout;

    logic [9:0] ch_val [4] = '{10'h123, 10'h2AB, 10'h055, 10'h3C7};

    int n_checks = 0;
    int n_pass   = 0;
    int eoc_delay = 12;
    int hold_cnt = 0, last_len = 0, cyc = 0, grant_cyc = 0, hold_cyc = 0, vcount = 0;
    logic busy_prev = 1'b0, hold_prev = 1'b0, valid_prev = 1'b0;

    sar_adc_scan_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_req(ch_req),
        .mux_sel(mux_sel), .adc_hold(adc_hold), .adc_eoc(adc_eoc),
        .adc_result(adc_result), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ch(res_ch), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // ADC model plus activity monitor: eoc on the eoc_delay-th hold-high cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (adc_hold) begin
            hold_cnt = hold_cnt + 1;
        end else begin
            if (hold_prev) last_len = hold_cnt;
            hold_cnt = 0;
        end
        adc_eoc    = adc_hold && (eoc_delay != 0) && (hold_cnt == eoc_delay);
        adc_result = adc_eoc ? ch_val[mux_sel] : 10'h000;
        if (busy && !busy_prev) grant_cyc = cyc;
        if (adc_hold && !hold_prev) hold_cyc = cyc;
        if (res_valid && !valid_prev) vcount = vcount + 1;
        busy_prev  = busy;
        hold_prev  = adc_hold;
        valid_prev = res_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mux"},   32'(mux_sel), 32'd0);
        check({tag, "_hold"},  32'(adc_hold), 32'd0);
        check({tag, "_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_data"},  32'(res_data), 32'd0);
        check({tag, "_ch"},    32'(res_ch), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_err"},   32'(err_timeout), 32'd0);
    endtask

    task automatic wait_result(input string tag, input logic [1:0] exp_ch);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!res_valid && n < 300);
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        check({tag, "_ch"},    32'(res_ch), 32'(exp_ch));
        check({tag, "_data"},  32'(res_data), 32'(ch_val[exp_ch]));
    endtask

    initial begin
        logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] pat   [3] = '{2'd0, 2'd2, 2'd0};
        int v0;
        int n;
        reset = 1'b1; enable = 1'b0; ch_req = 4'b0000; res_ready = 1'b0;
        tick(); tick(); tick();
        check_reset_outputs("rst");

        // Alternating requests 0101
        reset = 1'b0; enable = 1'b1; ch_req = 4'b0101; res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_result($sformatf("rr5_%0d", k), pat[k]);
            check($sformatf("settle_%0d", k), 32'(hold_cyc - grant_cyc), 32'd2);
            check($sformatf("len_%0d", k), 32'(last_len), 32'd12);
        end
        ch_req = 4'b0000;
        check("rr5_err", 32'(err_timeout), 32'd0);
        tick(); tick();

        // All channels requested
        do_reset();
        ch_req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_result($sformatf("rrf_%0d", k), order[k]);

        // Backpressure for 5 cycles
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_valid_%0d", k), 32'(res_valid), 32'd1);
            check($sformatf("bp_ch_%0d", k),    32'(res_ch), 32'd0);
            check($sformatf("bp_data_%0d", k),  32'(res_data), 32'(ch_val[0]));
            check($sformatf("bp_hold_%0d", k),  32'(adc_hold), 32'd0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_hs_valid", 32'(res_valid), 32'd0);
        check("bp_hs_busy",  32'(busy), 32'd0);
        tick();
        check("bp_grant_busy", 32'(busy), 32'd1);
        check("bp_grant_mux",  32'(mux_sel), 32'd1);
        wait_result("bp_next", 2'd1);
        ch_req = 4'b0000;

        // Timeout: ADC never answers
        do_reset();
        eoc_delay = 0; ch_req = 4'b0011; v0 = vcount; n = 0;
        do begin
            tick();
            n++;
        end while (!err_timeout && n < 300);
        check("to_err",    32'(err_timeout), 32'd1);
        check("to_hold",   32'(adc_hold), 32'd0);
        check("to_len",    32'(last_len), 32'd64);
        check("to_nores",  32'(vcount - v0), 32'd0);
        check("to_valid",  32'(res_valid), 32'd0);
        tick();
        check("to_next_busy", 32'(busy), 32'd1);
        check("to_next_mux",  32'(mux_sel), 32'd1);
        ch_req = 4'b0000;

        // eoc on the last allowed hold-high cycle
        do_reset();
        eoc_delay = 64; ch_req = 4'b0001;
        wait_result("edge", 2'd0);
        check("edge_err", 32'(err_timeout), 32'd0);
        check("edge_len", 32'(last_len), 32'd64);
        ch_req = 4'b0000;
        tick(); tick();

        // Reset during CONVERT
        do_reset();
        eoc_delay = 12; ch_req = 4'b0100; res_ready = 1'b0; n = 0;
        do begin
            tick();
            n++;
        end while (!adc_hold && n < 50);
        check("mc_hold_seen", 32'(adc_hold), 32'd1);
        tick(); tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("mc");

        // Reset during OUTPUT
        reset = 1'b0;
        wait_result("mo", 2'd2);
        tick();
        check("mo_stall", 32'(res_valid), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("mo");
        reset = 1'b0; ch_req = 4'b0101; res_ready = 1'b1; n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 20);
        check("post_busy", 32'(busy), 32'd1);
        check("post_mux",  32'(mux_sel), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_adc_scan_ctrl.md
# sar_adc_scan_ctrl

Round-robin multi-channel scan controller for the 10-bit SAR ADC. It selects an analog input channel, waits a settling interval, drives the ADC hold/start, and waits for end-of-conversion under a timeout. It then returns the result with its channel tag over a valid/ready interface. It sits between the ADC instance and the digital consumers.

## Interface
- `N_CH`, 4: number of analog channels (≥2).
- `N_BITS`, 10: ADC result width.
- `SETTLE_CYCLES`, 2: clk cycles between the mux change and hold assertion (≥1).
- `TIMEOUT`, 64: max clk cycles with hold high awaiting eoc (≥N_BITS+2).

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: permits new grants.
- `ch_req` in N_CH: level request mask, one bit per channel.
- `mux_sel` out $clog2(N_CH): analog mux select to the front end.
- `adc_hold` out 1: drives ADC `input_hold_digital`.
- `adc_eoc` in 1: ADC `eoc`.
- `adc_result` in N_BITS: ADC `output_result_digital`, valid while adc_eoc=1.
- `res_valid` out 1, `res_ready` in 1: result handshake.
- `res_data` out N_BITS, `res_ch` out $clog2(N_CH): result and channel tag.
- `busy` out 1: FSM not IDLE.
- `err_timeout` out 1: sticky timeout flag, cleared only by reset.

## Operation
- FSM states: IDLE, SETTLE, CONVERT, OUTPUT.
- IDLE: if enable && |ch_req, grant the next requested channel in round-robin order after `last_ch`; load mux_sel; go to SETTLE. Otherwise stay.
- SETTLE: count SETTLE_CYCLES; adc_hold=0; mux_sel stable; then go to CONVERT.
- CONVERT: adc_hold=1 held continuously; timeout counter increments.
  - If adc_eoc=1: latch adc_result into res_data and the granted channel into res_ch; update last_ch; go to OUTPUT.
  - Else, if the counter reaches TIMEOUT-1: set err_timeout; update last_ch (the failing channel loses its turn); go to IDLE with no result.
- OUTPUT: adc_hold=0; res_valid=1 until res_ready; on handshake go to IDLE.
- Request bits are sampled only at grant. Dropping a request mid-conversion does not abort it.
- enable=0 never aborts an in-flight conversion; it only blocks new grants.
- Round-robin: search starts at (last_ch+1) mod N_CH and wraps. After reset last_ch = N_CH-1, so channel 0 has first priority.

## Timing
- Reset values: state IDLE; mux_sel 0; adc_hold 0; res_valid 0; res_data 0; res_ch 0; busy 0; err_timeout 0; last_ch N_CH-1; counters 0.
- Grant at edge k puts mux_sel valid after edge k. adc_hold rises after edge k+SETTLE_CYCLES.
- eoc sampled high at edge e gives adc_hold=0 and res_valid=1 after edge e. Minimum eoc-to-result latency is 1 cycle.
- res_data and res_ch are stable while res_valid && !res_ready.
- If a request is pending, the next grant comes no earlier than 1 cycle after the handshake. adc_hold is low for at least SETTLE_CYCLES+1 cycles between conversions.
- If eoc and the timeout terminal count coincide, eoc wins: the result is taken and err_timeout stays unchanged.
- adc_eoc outside CONVERT is ignored.
- Reset asserted in any state returns all outputs to their reset values after that edge, with no partial result emitted.
- Counter widths: $clog2(max(SETTLE_CYCLES, TIMEOUT))+1 bits. Counters saturate and never wrap.

## Structure
- Package `sar_ctrl_pkg`: state enum `scan_state_t` {IDLE, SETTLE, CONVERT, OUTPUT}, defaults `N_BITS_DEF`=10 and `N_CH_DEF`=4.
- Sub-module `rr_arbiter`: combinational round-robin grant from `req[N_CH]` and `last[$clog2(N_CH)]`, outputs `gnt_idx` and `gnt_valid`.
- Top level holds the FSM, counters and output registers.

## Test plan
- After reset, ch_req=4'b0101, enable=1, ADC model eoc 12 cycles after hold, res_ready=1 → results tagged ch 0 then ch 2 then ch 0. adc_hold rises 2 cycles after each mux_sel change.
- ch_req=4'b1111 held → grant order 0,1,2,3,0, with no channel served twice before all others are served.
- res_ready=0 for 5 cycles after res_valid → res_data/res_ch stable, no new grant or hold; 1 cycle after ready=1 the next grant is issued.
- ADC never asserts eoc → err_timeout=1 and adc_hold=0 after exactly 64 hold-high cycles; no res_valid; the next channel is granted.
- eoc on the 64th hold-high cycle → result delivered and err_timeout stays 0.
- reset asserted mid-CONVERT and mid-OUTPUT → all outputs return to reset values after the next edge. After release, channel 0 is granted first.
